// File: rtl/tc_multi_if.sv
// Device-bus bundle for the timer/counter block: word address, byte-enabled
// write strobe and data, combinational read data and the combined IRQ line.
interface tc_multi_if;
    logic [3:0]  ADD_I;
    logic        WE_I;
    logic [3:0]  BE;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        IRQ;

    modport master (output ADD_I, WE_I, BE, DAT_I, input DAT_O, IRQ);
    modport slave  (input ADD_I, WE_I, BE, DAT_I, output DAT_O, IRQ);
endinterface

// File: rtl/tc_multi.sv
// Multi-channel down-counter timer: NCH channels of CTRL/PRESET/COUNT/STATUS,
// one-shot or auto-reload, sticky W1C pending bits OR-ed into a single IRQ.
module tc_multi_chan #(
    parameter int CW = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [1:0]  sel_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] dat_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    localparam logic [CW-1:0] ONE = CW'(1);

    state_t          state_q, state_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [CW-1:0]   preset_q, preset_d, count_q, count_d;
    logic            pend_q, pend_d;
    logic            en, reload, wr_ctrl, wr_preset, clr_pend;
    logic            unused_bits;

    assign en          = ctrl_q[0];
    assign reload      = |ctrl_q[2:1];
    assign wr_ctrl     = we_i && (sel_i == 2'd0);
    assign wr_preset   = we_i && (sel_i == 2'd1);
    assign clr_pend    = we_i && (sel_i == 2'd3) && be_i[0] && dat_i[0];
    assign unused_bits = ^{dat_i, be_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (en) state_d = LOAD;
            LOAD: state_d = CNT;
            CNT: begin
                if (!en)               state_d = IDLE;
                else if (count_q <= ONE) state_d = INT;
            end
            INT: state_d = reload ? CNT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Priority order matters: the INT set beats a W1C, a bus CTRL write beats
    // the one-shot EN clear.
    always_comb begin
        ctrl_d  = ctrl_q;
        count_d = count_q;
        pend_d  = pend_q;
        case (state_q)
            LOAD: count_d = preset_q;
            CNT:  if (en) count_d = (count_q > ONE) ? count_q - ONE : '0;
            INT: begin
                if (reload) count_d = preset_q;
                else        ctrl_d[0] = 1'b0;
            end
            default: ;
        endcase
        if (clr_pend)         pend_d = 1'b0;
        if (state_q == INT)   pend_d = 1'b1;
        if (wr_ctrl && be_i[0]) ctrl_d = dat_i[3:0];
    end

    for (genvar i = 0; i < CW; i++) begin : g_pre
        assign preset_d[i] = (wr_preset && be_i[i/8]) ? dat_i[i] : preset_q[i];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        case (sel_i)
            2'd0:    rdata_o = {28'b0, ctrl_q};
            2'd1:    rdata_o = 32'(preset_q);
            2'd2:    rdata_o = 32'(count_q);
            default: rdata_o = {31'b0, pend_q};
        endcase
    end

    assign irq_o = pend_q & ctrl_q[3];
endmodule

module tc_multi #(
    parameter int NCH = 2,
    parameter int CW  = 32
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    tc_multi_if.slave   bus
);
    logic [31:0] rd_ch [4];
    logic [3:0]  irq_ch;

    // Unpopulated channel slots read 0 and swallow writes.
    for (genvar c = 0; c < 4; c++) begin : g_ch
        if (c < NCH) begin : g_on
            tc_multi_chan #(.CW(CW)) u_ch (
                .clk_i   (CLK_I),
                .rst_i   (RST_I),
                .we_i    (bus.WE_I && (bus.ADD_I[3:2] == 2'(c))),
                .sel_i   (bus.ADD_I[1:0]),
                .be_i    (bus.BE),
                .dat_i   (bus.DAT_I),
                .rdata_o (rd_ch[c]),
                .irq_o   (irq_ch[c])
            );
        end else begin : g_off
            assign rd_ch[c]  = '0;
            assign irq_ch[c] = 1'b0;
        end
    end

    assign bus.DAT_O = rd_ch[bus.ADD_I[3:2]];
    assign bus.IRQ   = |irq_ch;
endmodule
